// File: rtl/branch_resolve_unit.sv
// Resolves MIPS branches from comparator lt/eq flags, then redirects fetch and flushes younger stages.
// Latency: redirect_valid rises one cycle after a taken accept; flush follows the redirect handshake for FLUSH_CYCLES cycles.
// Backpressure: redirect is held until redirect_ready; ready_in stays low until the unit returns to IDLE.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [2:0]       br_op,
    input  logic             lt,
    input  logic             eq,
    input  logic [31:0]      pc_plus4,
    input  logic [15:0]      imm,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    // Two extra codes keep the counter at least one bit wide when FLUSH_CYCLES is 0.
    localparam int FCW = $clog2(FLUSH_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t         state, state_nxt;
    logic [FCW-1:0] cnt, cnt_nxt;
    logic           accept;
    logic           taken;
    logic [31:0]    target;

    assign ready_in       = (state == IDLE);
    assign accept         = valid_in & ready_in;
    assign redirect_valid = (state == REDIRECT);
    assign flush          = (state == FLUSH);
    assign target         = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        taken = 1'b0;
        case (br_op)
            3'b001:  taken = eq;
            3'b010:  taken = ~eq;
            3'b011:  taken = lt | eq;
            3'b100:  taken = ~lt & ~eq;
            3'b101:  taken = lt;
            3'b110:  taken = ~lt;
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept && taken) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FCW'(FLUSH_CYCLES);
                    end
                end
            end
            FLUSH: begin
                cnt_nxt = cnt - FCW'(1);
                if (cnt == FCW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept && taken) begin
                redirect_pc <= target;
            end
        end
    end

    // Counters saturate at all-ones; clear_stats overrides any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_stats) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (accept && (br_op != 3'b000) && (br_count != {CNT_W{1'b1}})) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (accept && taken && (taken_count != {CNT_W{1'b1}})) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: main instance with default parameters, small instance with 2-bit counters and no flush.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lt, eq;
    logic [31:0] pc_plus4;
    logic [15:0] imm;

    logic        valid_in, ready_in, redirect_valid, redirect_ready, flush, clear_stats;
    logic [2:0]  br_op;
    logic [31:0] redirect_pc;
    logic [15:0] br_count, taken_count;

    logic        s_valid, s_ready, s_rvalid, s_rready, s_flush, s_clear;
    logic [2:0]  s_op;
    logic [31:0] s_rpc;
    logic [1:0]  s_br, s_taken;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) u_main (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
        .br_op(br_op), .lt(lt), .eq(eq), .pc_plus4(pc_plus4), .imm(imm),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .clear_stats(clear_stats),
        .br_count(br_count), .taken_count(taken_count)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(0), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .valid_in(s_valid), .ready_in(s_ready),
        .br_op(s_op), .lt(lt), .eq(eq), .pc_plus4(pc_plus4), .imm(imm),
        .redirect_valid(s_rvalid), .redirect_ready(s_rready),
        .redirect_pc(s_rpc), .flush(s_flush), .clear_stats(s_clear),
        .br_count(s_br), .taken_count(s_taken)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic l, input logic e,
                           input logic [31:0] pc, input logic [15:0] off);
        valid_in = 1'b1;
        br_op    = op;
        lt       = l;
        eq       = e;
        pc_plus4 = pc;
        imm      = off;
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; br_op = 3'b000; lt = 1'b0; eq = 1'b0;
        pc_plus4 = '0; imm = '0; redirect_ready = 1'b0; clear_stats = 1'b0;
        s_valid = 1'b0; s_op = 3'b000; s_rready = 1'b1; s_clear = 1'b0;
        step(); step();

        chk("rst_ready",  32'(ready_in), 32'd1);
        chk("rst_rvalid", 32'(redirect_valid), 32'd0);
        chk("rst_rpc",    redirect_pc, 32'd0);
        chk("rst_flush",  32'(flush), 32'd0);
        chk("rst_brcnt",  32'(br_count), 32'd0);
        chk("rst_tkcnt",  32'(taken_count), 32'd0);
        rst_n = 1'b1;

        // beq taken: 0x100 + 4*4 = 0x110
        present(3'b001, 1'b0, 1'b1, 32'h0000_0100, 16'h0004);
        step();
        valid_in = 1'b0;
        chk("beq_rvalid", 32'(redirect_valid), 32'd1);
        chk("beq_rpc",    redirect_pc, 32'h0000_0110);
        chk("beq_ready",  32'(ready_in), 32'd0);
        chk("beq_brcnt",  32'(br_count), 32'd1);
        chk("beq_tkcnt",  32'(taken_count), 32'd1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("beq_flush1",   32'(flush), 32'd1);
        chk("beq_rv_off",   32'(redirect_valid), 32'd0);
        step();
        chk("beq_flush2",   32'(flush), 32'd1);
        chk("beq_f2_ready", 32'(ready_in), 32'd0);
        step();
        chk("beq_flush_end", 32'(flush), 32'd0);
        chk("beq_ready_back", 32'(ready_in), 32'd1);

        // bne with eq=1 and bgez with lt=1 are both not taken
        present(3'b010, 1'b0, 1'b1, 32'h0000_0200, 16'h0010);
        step();
        present(3'b110, 1'b1, 1'b0, 32'h0000_0300, 16'h0010);
        step();
        valid_in = 1'b0;
        chk("nt_rvalid", 32'(redirect_valid), 32'd0);
        chk("nt_flush",  32'(flush), 32'd0);
        chk("nt_ready",  32'(ready_in), 32'd1);
        chk("nt_brcnt",  32'(br_count), 32'd3);
        chk("nt_tkcnt",  32'(taken_count), 32'd1);
        chk("nt_rpc",    redirect_pc, 32'h0000_0110);

        // op 000 is consumed without counting
        present(3'b000, 1'b0, 1'b1, 32'h0000_0400, 16'h0001);
        step();
        valid_in = 1'b0;
        chk("none_brcnt",  32'(br_count), 32'd3);
        chk("none_rvalid", 32'(redirect_valid), 32'd0);

        // bltz wraps: 8 + (-16) = 0xFFFFFFF8
        present(3'b101, 1'b1, 1'b0, 32'h0000_0008, 16'hFFFC);
        step();
        valid_in = 1'b0;
        chk("bltz_rpc",    redirect_pc, 32'hFFFF_FFF8);
        chk("bltz_rvalid", 32'(redirect_valid), 32'd1);

        // Stall fetch for 5 cycles while offering more branches
        for (int i = 0; i < 5; i++) begin
            present(3'b111, 1'b0, 1'b0, 32'h0000_1000, 16'h0040);
            step();
            chk("hold_rvalid", 32'(redirect_valid), 32'd1);
            chk("hold_rpc",    redirect_pc, 32'hFFFF_FFF8);
            chk("hold_ready",  32'(ready_in), 32'd0);
            chk("hold_brcnt",  32'(br_count), 32'd4);
            chk("hold_tkcnt",  32'(taken_count), 32'd2);
        end
        valid_in = 1'b0;
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("pre_rst_flush", 32'(flush), 32'd1);

        // Reset during the first flush cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_ready", 32'(ready_in), 32'd1);
        chk("mid_rst_brcnt", 32'(br_count), 32'd0);
        chk("mid_rst_tkcnt", 32'(taken_count), 32'd0);
        chk("mid_rst_rpc",   redirect_pc, 32'd0);

        // bgtz taken, negative offset: 0x200 - 4 = 0x1FC
        present(3'b100, 1'b0, 1'b0, 32'h0000_0200, 16'hFFFF);
        step();
        valid_in = 1'b0;
        chk("bgtz_rpc",    redirect_pc, 32'h0000_01FC);
        chk("bgtz_rvalid", 32'(redirect_valid), 32'd1);
        chk("bgtz_tkcnt",  32'(taken_count), 32'd1);

        // Small instance: four taken jumps saturate 2-bit counters at 3
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_op    = 3'b111;
            step();
            s_valid = 1'b0;
            chk("sm_rvalid", 32'(s_rvalid), 32'd1);
            step();
            chk("sm_ready",  32'(s_ready), 32'd1);
            chk("sm_noflush", 32'(s_flush), 32'd0);
        end
        chk("sm_tk_sat", 32'(s_taken), 32'd3);
        chk("sm_br_sat", 32'(s_br), 32'd3);

        // clear_stats beats a same-cycle accept
        s_valid = 1'b1;
        s_clear = 1'b1;
        s_op    = 3'b111;
        step();
        s_valid = 1'b0;
        s_clear = 1'b0;
        chk("sm_clr_tk", 32'(s_taken), 32'd0);
        chk("sm_clr_br", 32'(s_br), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
